uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter FSM between NUM_REQ byte producers.
- Accepts one byte per grant over a valid/ready handshake and launches it into the transmitter with a one-cycle start pulse.
- Holds the byte stable until the transmitter's busy flag has risen and then fallen again.
- Sits between the producer blocks (command/status sources) and the transmitter, which drives Txout.

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer that shares one UART transmitter FSM
//   between NUM_REQ byte producers. One byte is accepted per grant over a
//   valid/ready handshake, launched with a one-cycle tx_start pulse and held
//   on tx_data until the transmitter's busy flag has risen and fallen again.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [NUM_REQ]          per-requester byte available
//   req_data     [NUM_REQ*DATA_W]   packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ready    [NUM_REQ]          one-hot accept (combinational, IDLE only)
//   tx_busy      transmitter frame in progress
//   tx_start     one-cycle launch pulse
//   tx_data      [DATA_W]           byte to transmit (registered)
//   grant_id     [clog2(NUM_REQ)]   requester currently being served
//   active       high whenever the sequencer is not idle
//   timeout_err  one-cycle pulse when tx_busy never rose after a launch
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic                tx_start_q, tx_start_d;
  logic                active_q, active_d;
  logic                timeout_err_q, timeout_err_d;

  logic [DATA_W-1:0]   req_byte [NUM_REQ];
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Search rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ; the first valid wins.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // A grant is only offered while idle and the transmitter is free.
  assign grant = sel_found && (state_q == IDLE) && !tx_busy;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[sel_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          tx_data_d  = req_byte[sel_idx];
          grant_id_d = sel_idx;
          rr_ptr_d   = sel_idx;
          tx_start_d = 1'b1;   // registered, so it is high during LAUNCH
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // busy rising takes priority over a simultaneous timeout
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          cnt_d         = CNT_MAX;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= PTR_INIT;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      tx_start_q    <= 1'b0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      tx_start_q    <= tx_start_d;
      active_q      <= active_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed and randomized checks of uart_tx_arbiter (NUM_REQ=4, DATA_W=8,
//   TIMEOUT=15). Inputs change on the falling edge, outputs are checked there
//   too. The expected grant comes from a plain round-robin rule over the
//   valid mask; the bench itself plays the transmitter.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  logic [7:0]  bytes_v [N];
  int          last_gnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  assign req_data = {bytes_v[3], bytes_v[2], bytes_v[1], bytes_v[0]};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Round-robin reference: first valid index after the last grant.
  function automatic int model_pick(input int last, input logic [3:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // One complete frame, entered at a falling edge in IDLE with inputs set.
  // d = cycles after LAUNCH until tx_busy rises (0 = never, timeout);
  // b = busy length; after_mask = valid once accepted; pulse = one-cycle
  // extra valid bits during the busy phase.
  task automatic frame(input int d, input int b, input logic [3:0] after_mask,
                       input logic [3:0] pulse);
    int sel;
    sel = model_pick(last_gnt, req_valid);
    #1;
    chk("req_ready", 32'(req_ready), (sel < 0) ? 32'h0 : (32'h1 << sel));
    if (sel < 0) return;
    @(negedge clk);
    req_valid = after_mask;
    chk("tx_start_launch", 32'(tx_start), 32'h1);
    chk("tx_data", 32'(tx_data), 32'(bytes_v[sel]));
    chk("grant_id", 32'(grant_id), 32'(sel));
    chk("active_launch", 32'(active), 32'h1);
    last_gnt = sel;
    if (d == 0) begin
      for (int j = 1; j <= 15; j++) begin
        @(negedge clk);
        chk("timeout_early", 32'(timeout_err), 32'h0);
        chk("tx_start_wait", 32'(tx_start), 32'h0);
      end
      @(negedge clk);
      chk("timeout_pulse", 32'(timeout_err), 32'h1);
      chk("active_after_to", 32'(active), 32'h0);
    end else begin
      for (int j = 1; j <= d; j++) begin
        @(negedge clk);
        chk("tx_start_wb", 32'(tx_start), 32'h0);
        chk("timeout_wb", 32'(timeout_err), 32'h0);
        if (j == d) tx_busy = 1'b1;
      end
      for (int j = 1; j <= b; j++) begin
        @(negedge clk);
        if (j == 1) req_valid = req_valid | pulse;
        if (j == 2) req_valid = after_mask;
        #1;
        chk("active_busy", 32'(active), 32'h1);
        chk("tx_start_busy", 32'(tx_start), 32'h0);
        chk("ready_busy", 32'(req_ready), 32'h0);
        chk("timeout_busy", 32'(timeout_err), 32'h0);
        if (j == b) tx_busy = 1'b0;
      end
      @(negedge clk);
      chk("active_done", 32'(active), 32'h0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_active", 32'(active), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_gnt = N - 1;
  endtask

  logic [7:0] exp_seq [5];
  int         exp_ord [5];
  int         d_r, b_r;
  logic [3:0] m_r, a_r;

  initial begin
    exp_seq = '{8'hF0, 8'hE8, 8'hCC, 8'h00, 8'hF0};
    exp_ord = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req_valid = '0; tx_busy = 1'b0;
    for (int i = 0; i < N; i++) bytes_v[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    last_gnt = N - 1;

    // single requester, 20-cycle frame
    bytes_v[0] = 8'h38;
    req_valid  = 4'b0001;
    frame(2, 20, 4'b0000, 4'b0000);
    chk("hold_tx_data", 32'(tx_data), 32'h38);
    chk("hold_grant", 32'(grant_id), 32'h0);

    // all four valid, fixed bytes, rotation 0,1,2,3,0
    do_reset();
    bytes_v[0] = 8'hF0; bytes_v[1] = 8'hE8; bytes_v[2] = 8'hCC; bytes_v[3] = 8'h00;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      frame(1 + k, 3, 4'hF, 4'b0000);
      chk("rot_grant", 32'(grant_id), 32'(exp_ord[k]));
      chk("rot_data", 32'(tx_data), 32'(exp_seq[k]));
    end
    req_valid = '0;

    // transmitter never responds, then the next requester is served
    bytes_v[1] = 8'h5A;
    req_valid  = 4'b0011;
    frame(0, 0, 4'b0011, 4'b0000);
    frame(2, 3, 4'b0000, 4'b0000);
    // busy rising exactly when the counter would expire: no error
    req_valid = 4'b0100;
    frame(15, 2, 4'b0000, 4'b0000);

    // tx_busy held high in IDLE blocks the grant
    tx_busy   = 1'b1;
    req_valid = 4'b1000;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("busy_idle_ready", 32'(req_ready), 32'h0);
      chk("busy_idle_start", 32'(tx_start), 32'h0);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    frame(1, 2, 4'b0000, 4'b0000);
    chk("busy_idle_grant", 32'(grant_id), 32'h3);

    // reset during WAIT_DONE
    req_valid = 4'b0010;
    #1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_active", 32'(active), 32'h0);
    chk("arst_tx_data", 32'(tx_data), 32'h0);
    chk("arst_grant", 32'(grant_id), 32'h0);
    @(negedge clk);
    tx_busy = 1'b0; rst_n = 1'b1; last_gnt = N - 1;
    req_valid = 4'hF;
    frame(1, 2, 4'b0000, 4'b0000);
    chk("arst_prio0", 32'(grant_id), 32'h0);

    // reset during LAUNCH drops tx_start at once
    req_valid = 4'b0100;
    #1;
    @(negedge clk);
    req_valid = '0;
    chk("launch_start", 32'(tx_start), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("launch_rst_start", 32'(tx_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; last_gnt = N - 1;

    // requester 2 pulses valid while requester 1 is served
    req_valid = 4'b0010;
    frame(3, 5, 4'b0000, 4'b0100);
    chk("pulse_grant", 32'(grant_id), 32'h1);
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("pulse_no_ready", 32'(req_ready), 32'h0);
      chk("pulse_no_start", 32'(tx_start), 32'h0);
      @(negedge clk);
    end

    // randomized frames
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) bytes_v[i] = 8'($urandom);
      m_r = 4'($urandom_range(1, 15));
      a_r = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      d_r = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      b_r = $urandom_range(2, 6);
      req_valid = m_r;
      frame(d_r, b_r, a_r, 4'b0000);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
